// File: rtl/wb_arb2_rr_if.sv
// Wishbone bus bundle shared by the two requesting masters and the slave side
// of the round-robin arbiter. The master modport has no ERR input because the
// shared slave (USB device) has no error line; errors are generated by the
// arbiter itself towards its masters.
interface wb_arb2_rr_if #(
    parameter int ADR_W = 14,
    parameter int DAT_W = 32
);
    localparam int SEL_W = DAT_W / 8;

    logic             CYC;
    logic             STB;
    logic             WE;
    logic [ADR_W-1:0] ADR;
    logic [DAT_W-1:0] DAT_MOSI;
    logic [SEL_W-1:0] SEL;
    logic             ACK;
    logic             ERR;
    logic [DAT_W-1:0] DAT_MISO;

    // Bus initiator: drives the request, receives the response.
    modport master (
        output CYC, STB, WE, ADR, DAT_MOSI, SEL,
        input  ACK, DAT_MISO
    );

    // Bus target: receives the request, drives the response (including ERR).
    modport slave (
        input  CYC, STB, WE, ADR, DAT_MOSI, SEL,
        output ACK, ERR, DAT_MISO
    );
endinterface

// File: rtl/wb_arb2_rr.sv
// Two-master round-robin Wishbone arbiter in front of a single shared slave.
// Ownership is held for the whole bus cycle (CYC), ties alternate between the
// masters, and a per-transfer wait counter converts a silent slave into a
// one-cycle ERR to the owner followed by a recovery phase with the bus released.
module wb_arb2_rr #(
    parameter int ADR_W   = 14,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         ctrlCd_clk,
    input  logic         ctrlCd_reset,
    wb_arb2_rr_if.slave  m0,
    wb_arb2_rr_if.slave  m1,
    wb_arb2_rr_if.master s,
    output logic [1:0]   grant,
    output logic         timeout_sticky
);
    localparam int SEL_W = DAT_W / 8;

    // Wait-cycle limit and the count value at which the next unanswered
    // strobe cycle becomes the timeout cycle.
    localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // Registered arbitration state.
    state_t     state_q;
    logic       own_q;      // current owner index (valid in OWN/RECOVER)
    logic       last_q;     // last master that won arbitration
    logic [7:0] cnt_q;      // wait cycles of the current transfer
    logic [1:0] grant_q;
    logic       sticky_q;

    // Owner-selected request fields and decoded conditions.
    logic             own_cyc_s;
    logic             own_stb_s;
    logic             own_we_s;
    logic [ADR_W-1:0] own_adr_s;
    logic [DAT_W-1:0] own_dat_s;
    logic [SEL_W-1:0] own_sel_s;
    logic             in_own_s;
    logic             ack_fwd_s;
    logic             tmo_hit_s;
    logic             req_any_s;
    logic             win_s;

    // Owner multiplexing, timeout detection and next-winner selection.
    always_comb begin
        own_cyc_s = 1'b0;
        own_stb_s = 1'b0;
        own_we_s  = 1'b0;
        own_adr_s = '0;
        own_dat_s = '0;
        own_sel_s = '0;
        if (own_q) begin
            own_cyc_s = m1.CYC;
            own_stb_s = m1.STB;
            own_we_s  = m1.WE;
            own_adr_s = m1.ADR;
            own_dat_s = m1.DAT_MOSI;
            own_sel_s = m1.SEL;
        end else begin
            own_cyc_s = m0.CYC;
            own_stb_s = m0.STB;
            own_we_s  = m0.WE;
            own_adr_s = m0.ADR;
            own_dat_s = m0.DAT_MOSI;
            own_sel_s = m0.SEL;
        end

        in_own_s  = (state_q == ST_OWN);
        ack_fwd_s = in_own_s && s.ACK;
        // A slave ACK in the limit cycle wins over the timeout.
        tmo_hit_s = in_own_s && own_cyc_s && own_stb_s && !s.ACK &&
                    (cnt_q == TMO_LAST);

        req_any_s = m0.CYC || m1.CYC;
        // On a tie the master that did not win last time goes next.
        if (m0.CYC && m1.CYC) begin
            win_s = ~last_q;
        end else begin
            win_s = m1.CYC;
        end
    end

    // Slave-side request drive and master-side response routing.
    always_comb begin
        s.CYC      = 1'b0;
        s.STB      = 1'b0;
        s.WE       = 1'b0;
        s.ADR      = '0;
        s.DAT_MOSI = '0;
        s.SEL      = '0;
        if (in_own_s) begin
            s.CYC      = own_cyc_s;
            s.STB      = own_stb_s;
            s.WE       = own_we_s;
            s.ADR      = own_adr_s;
            s.DAT_MOSI = own_dat_s;
            s.SEL      = own_sel_s;
        end else begin
            s.CYC      = 1'b0;
        end

        m0.ACK      = ack_fwd_s && !own_q;
        m1.ACK      = ack_fwd_s &&  own_q;
        m0.ERR      = tmo_hit_s && !own_q;
        m1.ERR      = tmo_hit_s &&  own_q;
        // Read data is broadcast; only the ACKed owner will sample it.
        m0.DAT_MISO = s.DAT_MISO;
        m1.DAT_MISO = s.DAT_MISO;
    end

    // Arbitration FSM with owner, fairness, wait counter and status registers.
    always_ff @(posedge ctrlCd_clk) begin
        if (ctrlCd_reset) begin
            state_q  <= ST_IDLE;
            own_q    <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= 8'd0;
            grant_q  <= 2'b00;
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 8'd0;
                    if (req_any_s) begin
                        state_q <= ST_OWN;
                        own_q   <= win_s;
                        last_q  <= win_s;
                        grant_q <= win_s ? 2'b10 : 2'b01;
                    end else begin
                        grant_q <= 2'b00;
                    end
                end
                ST_OWN: begin
                    if (!own_cyc_s) begin
                        // Owner ended its cycle: release, one idle bubble.
                        state_q <= ST_IDLE;
                        grant_q <= 2'b00;
                        cnt_q   <= 8'd0;
                    end else if (s.ACK) begin
                        cnt_q <= 8'd0;
                    end else if (tmo_hit_s) begin
                        state_q  <= ST_RECOVER;
                        sticky_q <= 1'b1;
                        cnt_q    <= TMO_MAX;
                    end else if (own_stb_s && (cnt_q < TMO_MAX)) begin
                        cnt_q <= cnt_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                ST_RECOVER: begin
                    // Bus stays withdrawn until the faulted owner gives up.
                    if (!own_cyc_s) begin
                        state_q <= ST_IDLE;
                        grant_q <= 2'b00;
                        cnt_q   <= 8'd0;
                    end else begin
                        state_q <= ST_RECOVER;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign grant          = grant_q;
    assign timeout_sticky = sticky_q;
endmodule

// File: tb/tb_wb_arb2_rr.sv
// Self-checking bench for wb_arb2_rr: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model
// (owner index, fault flag, previous winner, wait count).
module tb_wb_arb2_rr;
    localparam int ADR_W = 14;
    localparam int DAT_W = 32;
    localparam int SEL_W = DAT_W / 8;
    localparam int TMO   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;
    logic       sticky;

    wb_arb2_rr_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) m0_bus ();
    wb_arb2_rr_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) m1_bus ();
    wb_arb2_rr_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) s_bus ();

    wb_arb2_rr #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TMO)) dut (
        .ctrlCd_clk     (clk),
        .ctrlCd_reset   (rst),
        .m0             (m0_bus.slave),
        .m1             (m1_bus.slave),
        .s              (s_bus.master),
        .grant          (grant),
        .timeout_sticky (sticky)
    );

    always #5 clk = ~clk;

    // Stimulus state
    logic             cyc_v [2];
    logic             stb_v [2];
    logic             we_v  [2];
    logic [ADR_W-1:0] adr_v [2];
    logic [DAT_W-1:0] dat_v [2];
    logic [SEL_W-1:0] sel_v [2];
    logic             sack;
    logic [DAT_W-1:0] smiso;

    // Reference model state
    int md_owner;    // -1 = nobody
    bit md_faulted;
    int md_prev;
    int md_waits;
    bit md_sticky;

    // Bookkeeping
    int         n_chk;
    int         n_fail;
    int         n_ack0, n_ack1, n_err0;
    logic [1:0] obs_grant;
    logic       obs_scyc, obs_ack0, obs_ack1, obs_err0;
    int         err_at;
    int         len_v [2];

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            cyc_v[n] = 1'b0; stb_v[n] = 1'b0; we_v[n] = 1'b0;
            adr_v[n] = '0;   dat_v[n] = '0;   sel_v[n] = '0;
        end
        sack  = 1'b0;
        smiso = 32'h0;
    endtask

    task automatic model_reset();
        md_owner = -1; md_faulted = 1'b0; md_prev = 1; md_waits = 0; md_sticky = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, clock, advance model.
    task automatic step();
        bit               bus_on;
        int               o;
        logic             e_cyc, e_stb, e_we;
        logic [ADR_W-1:0] e_adr;
        logic [DAT_W-1:0] e_dat;
        logic [SEL_W-1:0] e_sel;
        logic [1:0]       e_ack, e_err, e_grant;

        m0_bus.CYC = cyc_v[0]; m0_bus.STB = stb_v[0]; m0_bus.WE = we_v[0];
        m0_bus.ADR = adr_v[0]; m0_bus.DAT_MOSI = dat_v[0]; m0_bus.SEL = sel_v[0];
        m1_bus.CYC = cyc_v[1]; m1_bus.STB = stb_v[1]; m1_bus.WE = we_v[1];
        m1_bus.ADR = adr_v[1]; m1_bus.DAT_MOSI = dat_v[1]; m1_bus.SEL = sel_v[1];
        s_bus.ACK = sack; s_bus.DAT_MISO = smiso;
        #1;

        o = md_owner;
        bus_on = (o >= 0) && !md_faulted;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
        e_ack = 2'b00; e_err = 2'b00;
        if (bus_on) begin
            e_cyc = cyc_v[o]; e_stb = stb_v[o]; e_we = we_v[o];
            e_adr = adr_v[o]; e_dat = dat_v[o]; e_sel = sel_v[o];
            e_ack[o] = sack;
            e_err[o] = cyc_v[o] && stb_v[o] && !sack && (md_waits + 1 == TMO);
        end
        e_grant = (o < 0) ? 2'b00 : ((o == 1) ? 2'b10 : 2'b01);

        chk_eq("s_CYC", s_bus.CYC, e_cyc);
        chk_eq("s_STB", s_bus.STB, e_stb);
        chk_eq("s_WE", s_bus.WE, e_we);
        chk_eq("s_ADR", s_bus.ADR, e_adr);
        chk_eq("s_DAT_MOSI", s_bus.DAT_MOSI, e_dat);
        chk_eq("s_SEL", s_bus.SEL, e_sel);
        chk_eq("m0_ACK", m0_bus.ACK, e_ack[0]);
        chk_eq("m1_ACK", m1_bus.ACK, e_ack[1]);
        chk_eq("m0_ERR", m0_bus.ERR, e_err[0]);
        chk_eq("m1_ERR", m1_bus.ERR, e_err[1]);
        chk_eq("m0_DAT_MISO", m0_bus.DAT_MISO, smiso);
        chk_eq("m1_DAT_MISO", m1_bus.DAT_MISO, smiso);
        chk_eq("grant", grant, e_grant);
        chk_eq("timeout_sticky", sticky, md_sticky);

        obs_grant = grant; obs_scyc = s_bus.CYC;
        obs_ack0 = m0_bus.ACK; obs_ack1 = m1_bus.ACK; obs_err0 = m0_bus.ERR;
        if (m0_bus.ACK) n_ack0++;
        if (m1_bus.ACK) n_ack1++;
        if (m0_bus.ERR) n_err0++;

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (md_owner < 0) begin
            if (cyc_v[0] && cyc_v[1]) md_owner = 1 - md_prev;
            else if (cyc_v[0])        md_owner = 0;
            else if (cyc_v[1])        md_owner = 1;
            if (md_owner >= 0) begin
                md_prev  = md_owner;
                md_waits = 0;
            end
        end else if (!cyc_v[md_owner]) begin
            md_owner   = -1;
            md_faulted = 1'b0;
        end else if (!md_faulted) begin
            if (sack) begin
                md_waits = 0;
            end else if (stb_v[md_owner]) begin
                if (md_waits + 1 == TMO) begin
                    md_faulted = 1'b1;
                    md_sticky  = 1'b1;
                end else begin
                    md_waits++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();                         // reset state
        rst = 1'b0;

        // Single write from m0, slave answers on the third owned cycle
        do_reset();
        n_ack0 = 0; n_ack1 = 0;
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; we_v[0] = 1'b1;
        adr_v[0] = 14'h0010; dat_v[0] = 32'hDEADBEEF; sel_v[0] = 4'hF;
        step();
        chk_eq("wr_scyc_req_cycle", obs_scyc, 1'b0);
        step();
        chk_eq("wr_scyc_next_cycle", obs_scyc, 1'b1);
        step();
        sack = 1'b1;
        step();
        chk_eq("wr_grant", obs_grant, 2'b01);
        sack = 1'b0; cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
        step();
        chk_eq("wr_m0_ack_pulses", 64'(n_ack0), 64'd1);
        chk_eq("wr_m1_ack_pulses", 64'(n_ack1), 64'd0);

        // Three simultaneous requests: m0, m1, m0 with idle bubbles
        do_reset();
        for (int r = 0; r < 3; r++) begin
            cyc_v[0] = 1'b1; stb_v[0] = 1'b1; cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
            step();
            sack = 1'b1;
            step();
            chk_eq("tie_grant", obs_grant, (r == 1) ? 2'b10 : 2'b01);
            sack = 1'b0;
            cyc_v[0] = 1'b0; stb_v[0] = 1'b0; cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
            step();
            step();
            chk_eq("tie_bubble", obs_grant, 2'b00);
        end

        // m1 burst, m0 requests mid-burst: no preemption
        do_reset();
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            sack = 1'b1;
            if (b == 1) begin
                cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
            end
            step();
            chk_eq("burst_grant", obs_grant, 2'b10);
        end
        cyc_v[1] = 1'b0; stb_v[1] = 1'b0; sack = 1'b0;
        step();
        step();
        chk_eq("burst_bubble", obs_grant, 2'b00);
        step();
        chk_eq("burst_m0_grant", obs_grant, 2'b01);

        // Silent slave: m0 gets ERR on the 4th waiting strobe cycle
        do_reset();
        n_err0 = 0; err_at = -1;
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            if (obs_err0 && err_at < 0) err_at = k;
        end
        chk_eq("tmo_err_cycle", 64'(err_at), 64'd4);
        chk_eq("tmo_err_pulses", 64'(n_err0), 64'd1);
        chk_eq("tmo_scyc_recover", obs_scyc, 1'b0);
        chk_eq("tmo_sticky", sticky, 1'b1);
        chk_eq("tmo_grant_recover", grant, 2'b01);
        cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
        step();
        step();
        chk_eq("tmo_idle_grant", obs_grant, 2'b00);

        // ACK in the limit cycle wins over the timeout
        do_reset();
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) step();
        sack = 1'b1;
        step();
        chk_eq("late_ack_ack", obs_ack0, 1'b1);
        chk_eq("late_ack_err", obs_err0, 1'b0);
        sack = 1'b0; cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
        step();
        chk_eq("late_ack_sticky", sticky, 1'b0);

        // Reset while m1 owns with a pending response
        do_reset();
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; sack = 1'b1;
        step();
        chk_eq("rst_grant", obs_grant, 2'b00);
        chk_eq("rst_scyc", obs_scyc, 1'b0);
        chk_eq("rst_m1_ack", obs_ack1, 1'b0);

        // Random traffic against the model
        do_reset();
        len_v[0] = 0; len_v[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (cyc_v[n]) begin
                    if (len_v[n] == 0) cyc_v[n] = 1'b0;
                    else len_v[n]--;
                end else if ($urandom_range(3, 0) == 0) begin
                    cyc_v[n] = 1'b1;
                    len_v[n] = $urandom_range(12, 0);
                end
                stb_v[n] = cyc_v[n] && ($urandom_range(3, 0) != 0);
                we_v[n]  = 1'($urandom);
                adr_v[n] = ADR_W'($urandom);
                dat_v[n] = $urandom;
                sel_v[n] = SEL_W'($urandom);
            end
            sack  = ((c % 256) >= 40) && ($urandom_range(2, 0) == 0);
            smiso = $urandom;
            rst   = ($urandom_range(199, 0) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
